// File: rtl/dmem_pkg.sv
// Purpose: shared types and constants for the data-memory responder slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_pkg;

  localparam int WORD_W     = 32;
  localparam int LANES      = 4;
  // Held request address width; narrower bus addresses are zero-extended into it.
  localparam int REQ_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  wen;
    logic [REQ_ADDR_W-1:0] addr;
    logic [LANES-1:0]      mask;
    logic [WORD_W-1:0]     wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Purpose: load/store request + response bundle between the core (master) and dmem_responder (slave).
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
// Ports: req_valid, req_ready, req_wen, req_addr, req_mask, req_wdata,
//        resp_valid, resp_ready, resp_rdata, resp_err.
interface dmem_responder_if #(
  parameter int ADDR_W = 24
);
  import dmem_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_wen;
  logic [ADDR_W-1:0]   req_addr;
  logic [LANES-1:0]    req_mask;
  logic [WORD_W-1:0]   req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [WORD_W-1:0]   resp_rdata;
  logic                resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_mask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_mask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_bank.sv
// Purpose: word-wide storage array with per-byte-lane write enables; contents are never reset.
// Latency: write and read both take effect on the clk edge where en is high (read data registered).
// Backpressure: none; accepts an access every cycle en is high.
// Ports: clk, en (access strobe), we (1 = write), idx (word index), mask (lane enables),
//        wdata (lane-aligned write data), rdata (word read at the last enabled edge).
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LANES-1:0]  mask,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [0:(1<<IDX_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we && mask[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: target end of the core's load/store port; one request in flight, byte-masked stores, full-word loads.
// Latency: access LATENCY edges after accept, resp_valid LATENCY+1 edges after accept; next accept LATENCY+3 edges later.
// Backpressure: req_ready only in IDLE; response (rdata/err) held stable until resp_valid && resp_ready.
// Ports: clk, rst (async, active-high), bus (dmem_responder_if.slave).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int IDX_W   = 10,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  dmem_req_t         hold_q;
  dmem_req_t         req_in;
  dmem_req_t         src;
  logic              accept;
  logic              acc;
  logic              err;
  logic              bank_en;
  logic              acc_err_q;
  logic              rd_sel_q;
  logic [WORD_W-1:0] bank_rdata;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [WORD_W-1:0] resp_rdata_q;

  always_comb begin
    req_in       = '0;
    req_in.wen   = bus.req_wen;
    req_in.addr  = REQ_ADDR_W'(bus.req_addr);
    req_in.mask  = bus.req_mask;
    req_in.wdata = bus.req_wdata;
  end

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // With zero latency the access happens on the accept edge itself, so it
  // must use the live request rather than the not-yet-loaded holding register.
  assign src = ZERO_LAT ? req_in : hold_q;
  assign acc = ZERO_LAT ? accept : ((state == BUSY) && (cnt == 4'd0));

  assign err     = (src.addr[REQ_ADDR_W-1:IDX_W] != '0);
  // Gating with rst keeps a zero-latency request presented during reset from
  // reaching the array.
  assign bank_en = acc && !err && !rst;

  dmem_bank #(
    .IDX_W (IDX_W)
  ) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (src.wen),
    .idx   (src.addr[IDX_W-1:0]),
    .mask  (src.mask),
    .wdata (src.wdata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      hold_q       <= '0;
      acc_err_q    <= 1'b0;
      rd_sel_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      if (acc) begin
        acc_err_q <= err;
        rd_sel_q  <= !src.wen && !err;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            hold_q <= req_in;
            if (ZERO_LAT) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // First RESP cycle registers the response from the bank output;
          // it then holds until the requester takes it.
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err_q;
            resp_rdata_q <= rd_sel_q ? bank_rdata : '0;
          end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: directed bench for dmem_responder with a LATENCY=2 instance (a) and a LATENCY=0 instance (b).
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  dmem_responder_if #(.ADDR_W(24)) a ();
  dmem_responder_if #(.ADDR_W(24)) b ();

  dmem_responder #(.ADDR_W(24), .IDX_W(10), .LATENCY(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  dmem_responder #(.ADDR_W(24), .IDX_W(10), .LATENCY(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    a.req_valid = 1'b0; a.req_wen = 1'b0; a.req_addr = '0; a.req_mask = '0; a.req_wdata = '0; a.resp_ready = 1'b1;
    b.req_valid = 1'b0; b.req_wen = 1'b0; b.req_addr = '0; b.req_mask = '0; b.req_wdata = '0; b.resp_ready = 1'b1;
  endtask

  // Issues one request on instance a with resp_ready high; lat = edges from accept edge to resp_valid.
  task automatic req_a(input logic wen, input logic [23:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                       output int lat);
    int n;
    @(negedge clk);
    a.req_valid = 1'b1; a.req_wen = wen; a.req_addr = addr; a.req_mask = mask; a.req_wdata = wdata;
    a.resp_ready = 1'b1;
    n = 0;
    while (!a.req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    a.req_valid = 1'b0;
    lat = 0;
    while (!a.resp_valid && lat < 50) begin @(negedge clk); lat++; end
    checks++;
    if (!a.resp_valid) begin
      failures++;
      $display("FAIL req_a_timeout addr=%h: resp_valid=%b required 1", addr, a.resp_valid);
    end
    rdata = a.resp_rdata;
    err   = a.resp_err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checks++;
    if (a.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b required 0", a.resp_valid); end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (a.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", a.resp_valid); end
    checks++;
    if (a.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b required 1", a.req_ready); end
    checks++;
    if (a.resp_rdata !== 32'h0 || a.resp_err !== 1'b0) begin
      failures++; $display("FAIL rst_rdata_err: got %h/%b required 0/0", a.resp_rdata, a.resp_err);
    end
    checks++;
    if (b.req_ready !== 1'b1 || b.resp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_lat0: ready/valid got %b/%b required 1/0", b.req_ready, b.resp_valid);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    req_a(1'b1, 24'h000005, 4'b1111, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL store_latency: got %0d required 3", lat); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL store_err: got %b required 0", er); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL store_rdata: got %h required 00000000", rd); end
    req_a(1'b0, 24'h000005, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata: got %h required deadbeef", rd); end
    checks++;
    if (er !== 1'b0 || lat != 3) begin failures++; $display("FAIL load_err_lat: got %b/%0d required 0/3", er, lat); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; logic er; int lat;
    req_a(1'b1, 24'h000010, 4'b1111, 32'h11223344, rd, er, lat);
    req_a(1'b1, 24'h000010, 4'b0100, 32'h00AA0000, rd, er, lat);
    req_a(1'b0, 24'h000010, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11AA3344) begin failures++; $display("FAIL mask_lane2: got %h required 11aa3344", rd); end
    req_a(1'b1, 24'h000010, 4'b0000, 32'hFFFFFFFF, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL mask_zero_resp: got %b/%h required 0/00000000", er, rd); end
    req_a(1'b0, 24'h000010, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11AA3344) begin failures++; $display("FAIL mask_zero_word: got %h required 11aa3344", rd); end
  endtask

  task automatic test_back_pressure();
    int n;
    @(negedge clk);
    a.req_valid = 1'b1; a.req_wen = 1'b0; a.req_addr = 24'h000010; a.req_mask = '0; a.req_wdata = '0;
    a.resp_ready = 1'b0;
    @(negedge clk);
    // Second request presented immediately; must wait for the handshake.
    a.req_addr = 24'h000005;
    n = 0;
    while (!a.resp_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (a.resp_valid !== 1'b1 || a.resp_rdata !== 32'h11AA3344) begin
      failures++; $display("FAIL bp_first: valid/rdata got %b/%h required 1/11aa3344", a.resp_valid, a.resp_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({a.resp_valid, a.req_ready, a.resp_err, a.resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h11AA3344}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid/ready/err/rdata got %b/%b/%b/%h required 1/0/0/11aa3344",
                 i, a.resp_valid, a.req_ready, a.resp_err, a.resp_rdata);
      end
    end
    a.resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a.resp_valid !== 1'b0 || a.req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_after_hs: valid/ready got %b/%b required 0/1", a.resp_valid, a.req_ready);
    end
    @(negedge clk);
    a.req_valid = 1'b0;
    checks++;
    if (a.req_ready !== 1'b0) begin failures++; $display("FAIL bp_second_accept: ready got %b required 0", a.req_ready); end
    n = 0;
    while (!a.resp_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (a.resp_rdata !== 32'hDEADBEEF || n != 3) begin
      failures++; $display("FAIL bp_second_resp: rdata/lat got %h/%0d required deadbeef/3", a.resp_rdata, n);
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat;
    req_a(1'b1, 24'h000000, 4'b1111, 32'h12345678, rd, er, lat);
    req_a(1'b1, 24'h000400, 4'b1111, 32'hFFFFFFFF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL oor_store: err/rdata got %b/%h required 1/00000000", er, rd); end
    req_a(1'b0, 24'h000000, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h12345678) begin failures++; $display("FAIL oor_alias: err/rdata got %b/%h required 0/12345678", er, rd); end
    req_a(1'b0, 24'hFFFFFF, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL oor_load: err/rdata got %b/%h required 1/00000000", er, rd); end
  endtask

  task automatic test_lat0_back_to_back();
    int n;
    @(negedge clk);
    b.req_valid = 1'b1; b.req_wen = 1'b1; b.req_addr = 24'h000033; b.req_mask = 4'b1111;
    b.req_wdata = 32'hABCD1234; b.resp_ready = 1'b1;
    @(negedge clk);
    b.req_wen = 1'b0; b.req_mask = 4'b0000; b.req_wdata = 32'h0;
    checks++;
    if (b.resp_valid !== 1'b0) begin failures++; $display("FAIL lat0_early: valid got %b required 0", b.resp_valid); end
    n = 1;
    @(negedge clk);
    n++;
    checks++;
    if ({b.resp_valid, b.req_ready, b.resp_err, b.resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      failures++; $display("FAIL lat0_store_resp: valid/ready/err/rdata got %b/%b/%b/%h required 1/0/0/00000000",
                           b.resp_valid, b.req_ready, b.resp_err, b.resp_rdata);
    end
    while (!b.req_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 3) begin failures++; $display("FAIL lat0_spacing: got %0d required 3", n); end
    @(negedge clk);
    b.req_valid = 1'b0;
    n = 0;
    while (!b.resp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (b.resp_rdata !== 32'hABCD1234 || n != 1) begin
      failures++; $display("FAIL lat0_load: rdata/lat got %h/%0d required abcd1234/1", b.resp_rdata, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic er; int lat; logic seen;
    req_a(1'b1, 24'h000020, 4'b1111, 32'h55667788, rd, er, lat);
    @(negedge clk);
    a.req_valid = 1'b1; a.req_wen = 1'b1; a.req_addr = 24'h000020; a.req_mask = 4'b1111;
    a.req_wdata = 32'hCAFEF00D; a.resp_ready = 1'b1;
    @(negedge clk);
    a.req_valid = 1'b0;
    checks++;
    if (a.req_ready !== 1'b0) begin failures++; $display("FAIL mid_busy: ready got %b required 0", a.req_ready); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a.req_ready !== 1'b1 || a.resp_valid !== 1'b0) begin
      failures++; $display("FAIL mid_rst_state: ready/valid got %b/%b required 1/0", a.req_ready, a.resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_resp: valid seen %b required 0", seen); end
    req_a(1'b0, 24'h000020, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h55667788 || er !== 1'b0) begin
      failures++; $display("FAIL mid_discard: rdata/err got %h/%b required 55667788/0", rd, er);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_store_load();
    test_byte_mask();
    test_back_pressure();
    test_out_of_range();
    test_lat0_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store interface: the target end of the mem_ren/mem_wen/mem_addr/mem_mask/mem_wdata/mem_rdata signal set.
- Accepts one word-addressed request at a time through a valid/ready handshake.
- Models a configurable access latency and performs byte-masked writes and full-word reads on an internal array.
- Returns one response per request, for loads and stores alike, so the core can stall on memory.

Parameters:
- ADDR_W, 24, width of the word address (matches the core's mem_addr).
- IDX_W, 10, index bits of the local array; depth = 2**IDX_W words.
- LATENCY, 2, cycles spent in BUSY between accept and response; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address; byte address bits [ADDR_W+1:2].
- req_mask  in  4  byte-enable for stores, bit i enables byte lane i; ignored for loads.
- req_wdata  in  32  store data, already lane-aligned by the core.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  load data as a full word; 0 for stores and errors.
- resp_err  out  1  address out of range.

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset: state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, and req_ready = 1 once rst deasserts. Array contents are not reset.
- req_ready = (state == IDLE), decoded combinationally.
- Accept: a request is accepted on a clk edge where req_valid && req_ready. At that edge wen, addr, mask and wdata are captured into holding registers. Later input changes have no effect.
- IDLE to BUSY on accept when LATENCY > 0; the counter loads LATENCY-1.
- IDLE to RESP on accept when LATENCY == 0; the access is performed at the accept edge.
- BUSY: the counter decrements each cycle. When the counter == 0, the access is performed at that edge and the state moves to RESP.
  - Accept-to-resp_valid latency = LATENCY+1 cycles.
- Access, performed exactly once per request:
  - Range check: err = (addr[ADDR_W-1:IDX_W] != 0).
  - Store, not err: for each i with mask[i] = 1, array[idx][8i+7:8i] <= wdata[8i+7:8i]. Other lanes are unchanged.
  - Store with mask == 0: no lane changes, still responds.
  - Store response: resp_rdata = 0.
  - Load, not err: resp_rdata = array[idx], the full word. Lane selection (lbu) stays in the core.
  - Err: no array write, resp_rdata = 0, resp_err = 1.
- RESP: resp_valid = 1. resp_rdata and resp_err stay stable until resp_valid && resp_ready.
  - On that handshake edge the state moves to IDLE and resp_valid drops.
  - No request is accepted in the handshake cycle, so the minimum request-to-request spacing is LATENCY+3 cycles.
- Ordering:
  - A load after a store to the same word returns the stored bytes; no bypass is needed because the accesses are serial.
  - A store and a load never overlap.
- Reset mid-operation (rst in BUSY or RESP):
  - Return to IDLE immediately; drop resp_valid asynchronously.
  - A store still in BUSY is discarded and the array is untouched.
  - A store already committed stays committed.
- Widths: idx = addr[IDX_W-1:0]. The counter is 4 bits. No arithmetic is applied to data.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, BUSY, RESP}.
  - Constants WORD_W = 32 and LANES = 4.
  - A request struct {wen, addr, mask, wdata}.
- Sub-module dmem_bank (parameter IDX_W) holds the array:
  - Ports: clk, en, we, idx, mask, wdata, rdata.
  - Synchronous write with per-lane enable.
  - Read data registered on the same edge as the access.
  - No reset.
- dmem_responder keeps the FSM, the counter, the holding registers and the range check.

Test Plan:
- Reset with LATENCY = 2: assert rst mid-cycle → resp_valid = 0 and req_ready = 1 immediately after rst drops; store to addr 0x000005, mask 4'b1111, wdata 0xDEADBEEF → resp_valid rises 3 cycles after accept with resp_err = 0 and resp_rdata = 0; a following load of 0x000005 returns 0xDEADBEEF.
- Byte-masked stores: after word 0x11223344 at addr 0x10, store mask 4'b0100 with wdata 0x00AA0000 → a load returns 0x11AA3344; a store with mask 4'b0000 leaves the word 0x11AA3344.
- Back-pressure: hold resp_ready = 0 for 5 cycles after resp_valid → resp_rdata and resp_err stay constant, req_ready = 0 throughout, and a second req_valid is not accepted until the cycle after the handshake.
- Out of range: store to addr 0x000400 with IDX_W = 10 → resp_err = 1 and resp_rdata = 0; a load of 0x000000 shows the word unchanged, proving there is no aliasing write.
- LATENCY = 0 build: accept → resp_valid on the next edge; back-to-back store then load to the same word with resp_ready tied high → the load returns the stored data, and the spacing is 3 cycles.
- Reset mid-operation: accept a store of 0xCAFEF00D to 0x20, assert rst during BUSY → no response; after reset a load of 0x20 returns the prior contents, not 0xCAFEF00D.
